// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: two-requester round-robin arbiter in front of a single
// shared I2C master. The FSM walks IDLE -> LAUNCH -> WAIT -> DONE -> IDLE.
// It latches the winner's transaction fields, fires one start pulse to the
// master, waits for completion or timeout, and returns status to the winner.
module i2c_req_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [13:0] req_addr,
    input  logic [15:0] req_data,
    input  logic [1:0]  req_rw,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        timeout,
    output logic [7:0]  rdata,
    output logic        m_start,
    output logic [6:0]  m_addr,
    output logic [7:0]  m_data,
    output logic        m_rw,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_nack,
    input  logic [7:0]  m_rdata,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Last count value of a WAIT phase before the transaction is abandoned.
    localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYC - 1);

    state_t      state_r, state_nxt_s;

    logic [1:0]  gnt_r,      gnt_nxt_s;
    logic [1:0]  done_r,     done_nxt_s;
    logic        err_r,      err_nxt_s;
    logic        timeout_r,  timeout_nxt_s;
    logic [7:0]  rdata_r,    rdata_nxt_s;
    logic        m_start_r,  m_start_nxt_s;
    logic [6:0]  m_addr_r,   m_addr_nxt_s;
    logic [7:0]  m_data_r,   m_data_nxt_s;
    logic        m_rw_r,     m_rw_nxt_s;
    logic [15:0] wait_cnt_r, wait_cnt_nxt_s;
    logic        ptr_r,      ptr_nxt_s;
    logic        win_r,      win_nxt_s;
    logic        win_sel_s;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        win_sel_s = 1'b0;
        if (req == 2'b11) begin
            win_sel_s = ~ptr_r;
        end else begin
            win_sel_s = req[1];
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_nxt_s    = state_r;
        gnt_nxt_s      = gnt_r;
        done_nxt_s     = 2'b00;
        err_nxt_s      = err_r;
        timeout_nxt_s  = timeout_r;
        rdata_nxt_s    = rdata_r;
        m_start_nxt_s  = 1'b0;
        m_addr_nxt_s   = m_addr_r;
        m_data_nxt_s   = m_data_r;
        m_rw_nxt_s     = m_rw_r;
        wait_cnt_nxt_s = wait_cnt_r;
        ptr_nxt_s      = ptr_r;
        win_nxt_s      = win_r;

        case (state_r)
            ST_IDLE: begin
                if ((req != 2'b00) && !m_busy) begin
                    state_nxt_s   = ST_LAUNCH;
                    win_nxt_s     = win_sel_s;
                    gnt_nxt_s     = win_sel_s ? 2'b10 : 2'b01;
                    m_addr_nxt_s  = win_sel_s ? req_addr[13:7] : req_addr[6:0];
                    m_data_nxt_s  = win_sel_s ? req_data[15:8] : req_data[7:0];
                    m_rw_nxt_s    = win_sel_s ? req_rw[1] : req_rw[0];
                    m_start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s    = ST_WAIT;
                wait_cnt_nxt_s = 16'd0;
            end
            ST_WAIT: begin
                // A completion on the terminal count still counts as normal.
                if (m_done) begin
                    state_nxt_s   = ST_DONE;
                    err_nxt_s     = m_nack;
                    timeout_nxt_s = 1'b0;
                    rdata_nxt_s   = m_rdata;
                    done_nxt_s    = gnt_r;
                end else if (wait_cnt_r == TERM_CNT) begin
                    state_nxt_s   = ST_DONE;
                    err_nxt_s     = 1'b0;
                    timeout_nxt_s = 1'b1;
                    rdata_nxt_s   = 8'd0;
                    done_nxt_s    = gnt_r;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r + 16'd1;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = 2'b00;
                ptr_nxt_s   = win_r;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = 2'b00;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered outputs, counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_r      <= 2'b00;
            done_r     <= 2'b00;
            err_r      <= 1'b0;
            timeout_r  <= 1'b0;
            rdata_r    <= 8'd0;
            m_start_r  <= 1'b0;
            m_addr_r   <= 7'd0;
            m_data_r   <= 8'd0;
            m_rw_r     <= 1'b0;
            wait_cnt_r <= 16'd0;
            ptr_r      <= 1'b1;
            win_r      <= 1'b0;
        end else begin
            gnt_r      <= gnt_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            timeout_r  <= timeout_nxt_s;
            rdata_r    <= rdata_nxt_s;
            m_start_r  <= m_start_nxt_s;
            m_addr_r   <= m_addr_nxt_s;
            m_data_r   <= m_data_nxt_s;
            m_rw_r     <= m_rw_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            ptr_r      <= ptr_nxt_s;
            win_r      <= win_nxt_s;
        end
    end

    assign gnt     = gnt_r;
    assign done    = done_r;
    assign err     = err_r;
    assign timeout = timeout_r;
    assign rdata   = rdata_r;
    assign m_start = m_start_r;
    assign m_addr  = m_addr_r;
    assign m_data  = m_data_r;
    assign m_rw    = m_rw_r;
    assign state   = state_r;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Self-checking bench for i2c_req_arbiter with a 16-cycle timeout.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_i2c_req_arbiter;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [13:0] req_addr = 14'd0;
    logic [15:0] req_data = 16'd0;
    logic [1:0]  req_rw = 2'b00;
    logic [1:0]  gnt, done;
    logic        err, timeout;
    logic [7:0]  rdata;
    logic        m_start;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic        m_rw;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_nack = 1'b0;
    logic [7:0]  m_rdata = 8'd0;
    logic [1:0]  state;

    int total = 0;
    int bad = 0;
    int ptr_m = 1;   // reference model's last-served requester

    typedef struct packed {
        logic [1:0] gnt;
        logic       start;
        logic [6:0] maddr;
        logic [7:0] mdata;
        logic       mrw;
        logic [1:0] st_launch;
        logic       start_after;
        logic       stable;
        logic [1:0] done;
        logic       err;
        logic       tout;
        logic [7:0] rdata;
        int         wait_cyc;
        logic [1:0] post_done;
        logic [1:0] post_gnt;
        logic [1:0] post_state;
    } obs_t;

    i2c_req_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_data(req_data), .req_rw(req_rw), .gnt(gnt), .done(done),
        .err(err), .timeout(timeout), .rdata(rdata), .m_start(m_start),
        .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw), .m_busy(m_busy),
        .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata), .state(state)
    );

    always #5 clk = ~clk;

    // Expected observation of one transaction, from the arbitration rules.
    function automatic obs_t model_txn(input logic [1:0] rq, input logic [13:0] a,
                                       input logic [15:0] d, input logic [1:0] rw,
                                       input int dly, input logic nack, input logic [7:0] mrd);
        obs_t e;
        int   win;
        bit   normal;
        e = '0;
        if (rq == 2'b11) win = 1 - ptr_m;
        else             win = rq[1] ? 1 : 0;
        normal        = (dly >= 1) && (dly <= T);
        e.gnt         = (win == 1) ? 2'b10 : 2'b01;
        e.start       = 1'b1;
        e.maddr       = (win == 1) ? a[13:7] : a[6:0];
        e.mdata       = (win == 1) ? d[15:8] : d[7:0];
        e.mrw         = (win == 1) ? rw[1] : rw[0];
        e.st_launch   = 2'd1;
        e.start_after = 1'b0;
        e.stable      = 1'b1;
        e.done        = e.gnt;
        e.err         = normal ? nack : 1'b0;
        e.tout        = normal ? 1'b0 : 1'b1;
        e.rdata       = normal ? mrd : 8'd0;
        e.wait_cyc    = normal ? dly : T;
        return e;
    endfunction

    // Run one transaction from IDLE and record what the DUT shows.
    // dly = WAIT cycle on which m_done pulses (0 or > T: never in window).
    task automatic do_txn(input logic [1:0] rq, input logic [13:0] a, input logic [15:0] d,
                          input logic [1:0] rw, input int dly, input logic nack,
                          input logic [7:0] mrd, input bit drop, input bit noise,
                          output obs_t o);
        o = '0;
        req = rq; req_addr = a; req_data = d; req_rw = rw; m_done = 1'b0;
        @(negedge clk);
        o.st_launch = state; o.start = m_start; o.gnt = gnt;
        o.maddr = m_addr; o.mdata = m_data; o.mrw = m_rw;
        if (drop) req = 2'b00;
        m_done = noise;              // must be ignored during LAUNCH
        m_nack = 1'($urandom); m_rdata = 8'($urandom);
        @(negedge clk);
        o.start_after = m_start;
        o.wait_cyc = -1;
        for (int k = 1; k <= T + 4; k++) begin
            if (k == dly) begin
                m_done = 1'b1; m_nack = nack; m_rdata = mrd;
            end else begin
                m_done = 1'b0; m_nack = 1'($urandom); m_rdata = 8'($urandom);
            end
            @(negedge clk);
            m_done = 1'b0;
            if (state == 2'd3) begin
                o.wait_cyc = k;
                break;
            end
        end
        o.done = done; o.err = err; o.tout = timeout; o.rdata = rdata;
        o.stable = (m_addr == o.maddr) && (m_data == o.mdata) && (m_rw == o.mrw);
        m_done = noise;              // must be ignored during DONE
        @(negedge clk);
        m_done = 1'b0;
        o.post_done = done; o.post_gnt = gnt; o.post_state = state;
    endtask

    task automatic apply_reset();
        reset = 1'b1; req = 2'b00; m_done = 1'b0; m_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        ptr_m = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 2'b11; req_addr = 14'h3FFF; req_data = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({state, gnt, done, m_start, err, timeout, rdata, m_addr, m_data, m_rw} !== 34'd0) begin
            bad++;
            $display("FAIL reset_outputs: got st=%0d gnt=%b done=%b start=%b err=%b to=%b rdata=%h addr=%h data=%h rw=%b, want all 0",
                     state, gnt, done, m_start, err, timeout, rdata, m_addr, m_data, m_rw);
        end
        req = 2'b00; reset = 1'b0; ptr_m = 1;
        @(negedge clk);
        total++;
        if (state !== 2'd0 || gnt !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: got st=%0d gnt=%b, want st=0 gnt=00", state, gnt);
        end
    endtask

    task automatic test_single_write();
        obs_t o, e;
        e = model_txn(2'b01, {7'h00, 7'h51}, {8'h00, 8'hA5}, 2'b00, 3, 1'b0, 8'h00);
        do_txn(2'b01, {7'h00, 7'h51}, {8'h00, 8'hA5}, 2'b00, 3, 1'b0, 8'h00, 1'b0, 1'b0, o);
        ptr_m = e.gnt[1] ? 1 : 0;
        req = 2'b00;
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL single_write: got %h want %h", o, e);
        end
        total++;
        if (o.maddr !== 7'h51 || o.mdata !== 8'hA5 || o.done !== 2'b01 || o.err !== 1'b0) begin
            bad++;
            $display("FAIL single_write_fields: got addr=%h data=%h done=%b err=%b want 51 a5 01 0",
                     o.maddr, o.mdata, o.done, o.err);
        end
    endtask

    task automatic test_contention();
        obs_t o, e;
        int   dly;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            dly = int'($urandom_range(1, 5));
            e = model_txn(2'b11, 14'h1ABC, 16'h5AC3, 2'b01, dly, 1'b0, 8'h11);
            do_txn(2'b11, 14'h1ABC, 16'h5AC3, 2'b01, dly, 1'b0, 8'h11, 1'b0, 1'b0, o);
            ptr_m = e.gnt[1] ? 1 : 0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL contention_txn%0d: got %h want %h", i, o, e);
            end
            total++;
            if (o.gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10) || o.done !== o.gnt) begin
                bad++;
                $display("FAIL contention_order%0d: got gnt=%b done=%b want gnt=%b",
                         i, o.gnt, o.done, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_read_nack();
        obs_t o, e;
        e = model_txn(2'b10, {7'h52, 7'h00}, 16'h0000, 2'b10, 4, 1'b1, 8'hC6);
        do_txn(2'b10, {7'h52, 7'h00}, 16'h0000, 2'b10, 4, 1'b1, 8'hC6, 1'b0, 1'b1, o);
        ptr_m = e.gnt[1] ? 1 : 0;
        req = 2'b00;
        total++;
        if (o !== e || o.done !== 2'b10 || o.err !== 1'b1 || o.rdata !== 8'hC6 || o.mrw !== 1'b1) begin
            bad++;
            $display("FAIL read_nack: got %h want %h", o, e);
        end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        int   dlys [3] = '{0, T, T + 1};
        for (int i = 0; i < 3; i++) begin
            e = model_txn(2'b01, 14'h0023, 16'h0077, 2'b00, dlys[i], 1'b1, 8'h9E);
            do_txn(2'b01, 14'h0023, 16'h0077, 2'b00, dlys[i], 1'b1, 8'h9E, 1'b0, 1'b0, o);
            ptr_m = e.gnt[1] ? 1 : 0;
            req = 2'b00;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL timeout_case%0d: got %h want %h", i, o, e);
            end
            total++;
            if (o.wait_cyc != T || o.tout !== (dlys[i] != T)) begin
                bad++;
                $display("FAIL timeout_cycle%0d: got wait=%0d to=%b want wait=%0d to=%b",
                         i, o.wait_cyc, o.tout, T, (dlys[i] != T));
            end
        end
    endtask

    task automatic test_busy();
        obs_t o, e;
        m_busy = 1'b1; req = 2'b01; req_addr = 14'h0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (state !== 2'd0 || gnt !== 2'b00 || m_start !== 1'b0) begin
                bad++;
                $display("FAIL busy_hold%0d: got st=%0d gnt=%b start=%b want 0 00 0", i, state, gnt, m_start);
            end
        end
        m_busy = 1'b0;
        e = model_txn(2'b01, 14'h0011, 16'h0022, 2'b01, 2, 1'b0, 8'h33);
        do_txn(2'b01, 14'h0011, 16'h0022, 2'b01, 2, 1'b0, 8'h33, 1'b1, 1'b0, o);
        ptr_m = e.gnt[1] ? 1 : 0;
        req = 2'b00;
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL busy_release: got %h want %h", o, e);
        end
    endtask

    task automatic test_reset_wait();
        req = 2'b01; req_addr = 14'h0055; req_data = 16'h00AA; req_rw = 2'b01;
        @(negedge clk);     // LAUNCH
        @(negedge clk);     // WAIT cycle 1
        @(negedge clk);     // WAIT cycle 2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req = 2'b00; ptr_m = 1;
        total++;
        if (state !== 2'd0 || gnt !== 2'b00 || done !== 2'b00 || m_addr !== 7'd0 || m_data !== 8'd0 || m_rw !== 1'b0) begin
            bad++;
            $display("FAIL reset_wait: got st=%0d gnt=%b done=%b addr=%h data=%h rw=%b want all 0",
                     state, gnt, done, m_addr, m_data, m_rw);
        end
        m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hEE;
        @(negedge clk);
        m_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (state !== 2'd0 || done !== 2'b00 || err !== 1'b0 || rdata !== 8'd0) begin
                bad++;
                $display("FAIL stray_mdone%0d: got st=%0d done=%b err=%b rdata=%h want 0 00 0 00",
                         i, state, done, err, rdata);
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [1:0]  rq;
        logic [13:0] a;
        logic [15:0] d;
        logic [1:0]  rw;
        int          dly;
        logic        nack;
        logic [7:0]  mrd;
        for (int i = 0; i < 30; i++) begin
            rq   = 2'($urandom_range(1, 3));
            a    = 14'($urandom);
            d    = 16'($urandom);
            rw   = 2'($urandom);
            dly  = int'($urandom_range(0, T + 2));
            nack = 1'($urandom);
            mrd  = 8'($urandom);
            e = model_txn(rq, a, d, rw, dly, nack, mrd);
            do_txn(rq, a, d, rw, dly, nack, mrd, 1'($urandom), 1'($urandom), o);
            ptr_m = e.gnt[1] ? 1 : 0;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL random_txn%0d: req=%b dly=%0d got %h want %h", i, rq, dly, o, e);
            end
            if ($urandom_range(0, 2) == 0) begin
                req = 2'b00;
                @(negedge clk);
            end
        end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_read_nack();
        test_timeout();
        test_busy();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
